// File: rtl/usb_reg_pkg.sv
// Shared definitions for the USB host register bridge: FSM encoding,
// CTRL/STATUS bit positions and the STATUS byte packer.
package usb_reg_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_ACTIVE = 3'd1,
    RD_FETCH  = 3'd2,
    RD_HOLD   = 3'd3,
    RD_TAIL   = 3'd4
  } state_t;

  localparam int ADDR_W = 21;
  localparam int BUS_W  = 8;

  localparam int CTRL_GO_BIT       = 0;
  localparam int CTRL_CLR_DONE_BIT = 1;
  localparam int CTRL_CLR_ERR_BIT  = 2;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

  function automatic logic [BUS_W-1:0] status_byte(input logic err, input logic done_sticky,
                                                   input logic busy);
    logic [BUS_W-1:0] s;
    s                = '0;
    s[STAT_BUSY_BIT] = busy;
    s[STAT_DONE_BIT] = done_sticky;
    s[STAT_ERR_BIT]  = err;
    return s;
  endfunction

endpackage

// File: rtl/usb_sync.sv
// Multi-flop synchronizer for an asynchronous host pin group; resets to all zero.
module usb_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_usb,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = din;
    for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  always_ff @(posedge clk_usb) begin
    for (int i = 0; i < STAGES; i++) begin
      if (reset) sync_q[i] <= '0;
      else       sync_q[i] <= sync_d[i];
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/usb_reg_bridge.sv
// Asynchronous host bus (cen/rd/wr strobes) to register/memory bridge with
// byte memory, CTRL/STATUS register and a tri-stated read data bus.
module usb_reg_bridge
  import usb_reg_pkg::*;
#(
  parameter int MEMORY_WIDTH = 8,
  parameter int MEMORY_BYTES = 1 << MEMORY_WIDTH,
  parameter int SYNC_STAGES  = 2,
  parameter int RDDLY_LEN    = 3
) (
  input  logic                      clk_usb,
  input  logic                      reset,
  inout  wire  [BUS_W-1:0]          data,
  input  logic [ADDR_W-1:0]         addr,
  input  logic                      rd_en,
  input  logic                      wr_en,
  input  logic                      cen,
  output logic [MEMORY_BYTES*8-1:0] memory_input,
  input  logic [MEMORY_BYTES*8-1:0] memory_output,
  output logic                      go,
  input  logic                      busy,
  input  logic                      done,
  output logic                      wr_pulse,
  output logic [MEMORY_WIDTH-1:0]   wr_index
);

  localparam int TAIL_W  = (RDDLY_LEN > 1) ? $clog2(RDDLY_LEN) : 1;
  localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(MEMORY_BYTES);

  // Strobes are synchronized active-high so a reset synchronizer reads as "bus idle".
  logic [2:0]        strb_s;
  logic [ADDR_W-1:0] addr_s;
  logic [BUS_W-1:0]  data_s;
  logic              cs_a, wr_a, rd_a;

  usb_sync #(.WIDTH(3), .STAGES(SYNC_STAGES)) u_sync_strb (
    .clk_usb(clk_usb), .reset(reset), .din({~cen, ~wr_en, ~rd_en}), .dout(strb_s));
  usb_sync #(.WIDTH(ADDR_W), .STAGES(SYNC_STAGES)) u_sync_addr (
    .clk_usb(clk_usb), .reset(reset), .din(addr), .dout(addr_s));
  usb_sync #(.WIDTH(BUS_W), .STAGES(SYNC_STAGES)) u_sync_data (
    .clk_usb(clk_usb), .reset(reset), .din(data), .dout(data_s));

  assign {cs_a, wr_a, rd_a} = strb_s;

  state_t                    state_q, state_d;
  logic [MEMORY_BYTES*8-1:0] mem_q, mem_d;
  logic [ADDR_W-1:0]         waddr_q, waddr_d;
  logic [BUS_W-1:0]          wdata_q, wdata_d;
  logic [BUS_W-1:0]          data_out_q, data_out_d;
  logic                      go_q, go_d, wr_pulse_q, wr_pulse_d;
  logic [MEMORY_WIDTH-1:0]   wr_index_q, wr_index_d;
  logic                      done_q, done_d, err_q, err_d;
  logic [TAIL_W-1:0]         tail_cnt_q, tail_cnt_d;
  logic [FLUSH_W-1:0]        flush_q, flush_d;
  logic                      armed_q, armed_d;
  logic [BUS_W-1:0]          rd_byte;
  logic                      drive;

  always_ff @(posedge clk_usb) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Nothing starts until the host has been seen idle after reset (armed_q).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (armed_q && cs_a) begin
          if (wr_a && !rd_a)      state_d = WR_ACTIVE;
          else if (rd_a && !wr_a) state_d = RD_FETCH;
        end
      end
      WR_ACTIVE: if (!wr_a || !cs_a) state_d = IDLE;
      RD_FETCH:  state_d = RD_HOLD;
      RD_HOLD:   if (!rd_a) state_d = RD_TAIL;
      RD_TAIL:   if (tail_cnt_q == '0) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_byte = '0;
    if (addr_s < CTRL_ADDR)       rd_byte = memory_output[{addr_s[MEMORY_WIDTH-1:0], 3'b000} +: 8];
    else if (addr_s == CTRL_ADDR) rd_byte = status_byte(err_q, done_q, busy);
  end

  always_comb begin
    mem_d      = mem_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    go_d       = 1'b0;
    wr_pulse_d = 1'b0;
    wr_index_d = wr_index_q;
    done_d     = done_q;
    err_d      = err_q;
    tail_cnt_d = tail_cnt_q;
    flush_d    = (flush_q != '0) ? flush_q - 1'b1 : flush_q;
    armed_d    = armed_q | ((flush_q == '0) && !rd_a && !wr_a);

    unique case (state_q)
      IDLE: if (armed_q && cs_a && rd_a && wr_a) err_d = 1'b1;
      WR_ACTIVE: begin
        waddr_d = addr_s;
        wdata_d = data_s;
        // Commit uses the value registered before the strobe rose.
        if (!wr_a) begin
          if (waddr_q < CTRL_ADDR) begin
            mem_d[{waddr_q[MEMORY_WIDTH-1:0], 3'b000} +: 8] = wdata_q;
            wr_pulse_d = 1'b1;
            wr_index_d = waddr_q[MEMORY_WIDTH-1:0];
          end else if (waddr_q == CTRL_ADDR) begin
            go_d = wdata_q[CTRL_GO_BIT];
            if (wdata_q[CTRL_CLR_DONE_BIT]) done_d = 1'b0;
            if (wdata_q[CTRL_CLR_ERR_BIT])  err_d  = 1'b0;
          end
        end
      end
      RD_FETCH: data_out_d = rd_byte;
      RD_HOLD:  if (!rd_a) tail_cnt_d = TAIL_W'(RDDLY_LEN - 1);
      RD_TAIL:  if (tail_cnt_q != '0) tail_cnt_d = tail_cnt_q - 1'b1;
      default: ;
    endcase

    if (done) done_d = 1'b1;
  end

  always_ff @(posedge clk_usb) begin
    if (reset) begin
      mem_q      <= '0;
      data_out_q <= '0;
      go_q       <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_index_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tail_cnt_q <= '0;
      flush_q    <= FLUSH_W'(SYNC_STAGES);
      armed_q    <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      data_out_q <= data_out_d;
      go_q       <= go_d;
      wr_pulse_q <= wr_pulse_d;
      wr_index_q <= wr_index_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tail_cnt_q <= tail_cnt_d;
      flush_q    <= flush_d;
      armed_q    <= armed_d;
    end
  end

  always_ff @(posedge clk_usb) begin
    waddr_q <= waddr_d;
    wdata_q <= wdata_d;
  end

  assign drive        = ((state_q == RD_HOLD) || (state_q == RD_TAIL)) && !reset;
  assign data         = drive ? data_out_q : {BUS_W{1'bz}};
  assign memory_input = mem_q;
  assign go           = go_q;
  assign wr_pulse     = wr_pulse_q;
  assign wr_index     = wr_index_q;

endmodule

// File: tb/tb_usb_reg_bridge.sv
// Directed bench for usb_reg_bridge with write/read scoreboard queues.
module tb_usb_reg_bridge;

  localparam int MW   = 8;
  localparam int MB   = 1 << MW;
  localparam int SYNC = 2;
  localparam int RDD  = 3;

  logic clk_usb = 1'b0;
  always #5 clk_usb = ~clk_usb;

  logic             reset = 1'b1;
  wire  [7:0]       data;
  logic [7:0]       tb_drv = 8'h00;
  logic             tb_en = 1'b0;
  logic [20:0]      addr = '0;
  logic             rd_en = 1'b1, wr_en = 1'b1, cen = 1'b1;
  logic [MB*8-1:0]  memory_input;
  logic [MB*8-1:0]  memory_output = '0;
  logic             go, wr_pulse;
  logic             busy = 1'b0, done = 1'b0;
  logic [MW-1:0]    wr_index;

  assign data = tb_en ? tb_drv : 8'bz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data[g]);
  end

  usb_reg_bridge #(.MEMORY_WIDTH(MW), .MEMORY_BYTES(MB), .SYNC_STAGES(SYNC), .RDDLY_LEN(RDD)) dut (
    .clk_usb(clk_usb), .reset(reset), .data(data), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
    .cen(cen), .memory_input(memory_input), .memory_output(memory_output), .go(go),
    .busy(busy), .done(done), .wr_pulse(wr_pulse), .wr_index(wr_index));

  typedef struct {
    logic [7:0] idx;
    logic [7:0] val;
  } wexp_t;

  int         total = 0;
  int         bad = 0;
  int         go_cnt = 0;
  wexp_t      wq[$];
  wexp_t      we;
  logic [7:0] rq[$];
  logic [MB*8-1:0] exp_mem = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    total++;
    assert (memory_input === exp_mem) else begin
      bad++;
      for (int i = 0; i < MB; i++) begin
        if (memory_input[i*8+:8] !== exp_mem[i*8+:8]) begin
          $error("FAIL %s byte=%0d observed=%02h expected=%02h", tag, i,
                 memory_input[i*8+:8], exp_mem[i*8+:8]);
          break;
        end
      end
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk_usb);
    #1;
  endtask

  task automatic host_write(input logic [20:0] a, input logic [7:0] v, input bit with_done = 0);
    if (a < MB) begin
      wq.push_back('{a[7:0], v});
      exp_mem[int'(a)*8 +: 8] = v;
    end
    addr = a; tb_drv = v; tb_en = 1'b1;
    cen = 1'b0; wr_en = 1'b0;
    step(6);
    wr_en = 1'b1;
    step(2);
    if (with_done) done = 1'b1;
    step();
    done = 1'b0;
    step();
    cen = 1'b1;
    step();
    tb_en = 1'b0;
    step(2);
  endtask

  task automatic host_read(input logic [20:0] a, input logic [7:0] exp);
    logic [7:0] got;
    rq.push_back(exp);
    addr = a; cen = 1'b0; rd_en = 1'b0;
    step(SYNC + 1);
    check($sformatf("rd_predrive@%0h", a), data, 8'hFF);
    step();
    got = rq.pop_front();
    check($sformatf("rd_data@%0h", a), data, got);
    step(2);
    rd_en = 1'b1;
    step(SYNC + RDD);
    check($sformatf("rd_tail_drive@%0h", a), data, got);
    step();
    check($sformatf("rd_release@%0h", a), data, 8'hFF);
    cen = 1'b1;
    step(3);
  endtask

  always @(negedge clk_usb) begin
    if (!reset && go) go_cnt++;
    if (!reset && wr_pulse) begin
      if (wq.size() == 0) begin
        check("wr_pulse_unexpected", 32'(wr_pulse), 32'd0);
      end else begin
        we = wq.pop_front();
        check("wr_index", 32'(wr_index), 32'(we.idx));
        check("wr_byte", 32'(memory_input[int'(we.idx)*8 +: 8]), 32'(we.val));
      end
    end
  end

  initial begin
    for (int i = 0; i < MB; i++) memory_output[i*8 +: 8] = 8'($urandom_range(0, 254));
    memory_output[8'h10*8 +: 8] = 8'h3C;
    memory_output[8'hFF*8 +: 8] = 8'h81;

    step(3);
    check("reset_data_hiz", data, 8'hFF);
    check("reset_go", go, 1'b0);
    check("reset_wr_pulse", wr_pulse, 1'b0);
    check("reset_wr_index", wr_index, 8'h00);
    check_mem("reset_mem");
    reset = 1'b0;
    step(4);

    host_write(21'h003, 8'hA5);
    check_mem("mem_w003");
    step(5);
    check("wr_index_hold", wr_index, 8'h03);
    host_write(21'h0FF, 8'h5A);
    check_mem("mem_w0ff");

    host_read(21'h010, 8'h3C);
    host_read(21'h0FF, 8'h81);

    go_cnt = 0;
    host_write(21'h100, 8'h01);
    check("go_once", go_cnt, 1);
    check("wr_index_ctrl", wr_index, 8'hFF);

    done = 1'b1; step(); done = 1'b0; step(2);
    host_read(21'h100, 8'h02);
    busy = 1'b1;
    host_read(21'h100, 8'h03);
    busy = 1'b0;
    go_cnt = 0;
    host_write(21'h100, 8'h02);
    check("go_none", go_cnt, 0);
    host_read(21'h100, 8'h00);

    host_read(21'h1FFFFF, 8'h00);
    host_read(21'h101, 8'h00);
    host_write(21'h000200, 8'h77);
    host_write(21'h010003, 8'h55);
    check_mem("mem_unmapped");

    addr = 21'h020; cen = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    step(SYNC + 3);
    check("both_low_nodrive", data, 8'hFF);
    step(3);
    check("both_low_nodrive2", data, 8'hFF);
    rd_en = 1'b1; wr_en = 1'b1;
    step(2);
    cen = 1'b1;
    step(3);
    check_mem("mem_both_low");
    host_read(21'h100, 8'h04);
    host_write(21'h100, 8'h04);
    host_read(21'h100, 8'h00);

    host_write(21'h100, 8'h02, 1);
    host_read(21'h100, 8'h02);
    host_write(21'h100, 8'h02);
    host_read(21'h100, 8'h00);

    addr = 21'h004; tb_drv = 8'hEE; tb_en = 1'b1; cen = 1'b0; wr_en = 1'b0;
    step(6);
    cen = 1'b1;
    step(4);
    wr_en = 1'b1;
    step(4);
    tb_en = 1'b0;
    check_mem("mem_abort");

    addr = 21'h010; cen = 1'b0; rd_en = 1'b0;
    step(SYNC + 2);
    check("rst_pre_drive", data, 8'h3C);
    reset = 1'b1;
    step();
    check("rst_hiz", data, 8'hFF);
    exp_mem = '0;
    check_mem("mem_reset");
    check("rst_wr_index", wr_index, 8'h00);
    step();
    reset = 1'b0;
    step(8);
    check("rst_no_rearm", data, 8'hFF);
    step(4);
    check("rst_no_rearm2", data, 8'hFF);
    rd_en = 1'b1; cen = 1'b1;
    step(3);
    host_read(21'h010, 8'h3C);
    host_write(21'h007, 8'h42);
    check_mem("mem_after_reset_write");

    step(4);
    check("wr_queue_empty", wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_reg_bridge.md
USB_REG_BRIDGE -- requirements
Module: usb_reg_bridge

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; every flop SHALL be clocked by clk_usb.
REQ-002 The block SHALL have these parameters:
- MEMORY_WIDTH, default 8, byte-address bits per memory region.
- MEMORY_BYTES, default 1<<MEMORY_WIDTH, region size.
- SYNC_STAGES, default 2 (minimum 2), bus-pin synchronizer depth.
- RDDLY_LEN, default 3 (minimum 1), data-drive tail cycles after read end.
REQ-003 The block SHALL have these ports:
- clk_usb  in  1  system/USB clock.
- reset  in  1  synchronous active-high reset.
- data  inout  8  host data bus.
- addr  in  21  host address.
- rd_en  in  1  active-low read strobe.
- wr_en  in  1  active-low write strobe.
- cen  in  1  active-low chip enable.
- memory_input  out  MEMORY_BYTES*8  host-written bytes; byte i at [i*8+:8].
- memory_output  in  MEMORY_BYTES*8  bytes readable by the host.
- go  out  1  one-cycle start pulse.
- busy  in  1  core busy level.
- done  in  1  core done pulse.
- wr_pulse  out  1  one-cycle write-commit strobe.
- wr_index  out  MEMORY_WIDTH  byte index of the last commit.

Function
REQ-004 rd_en, wr_en, cen, addr and data SHALL each pass through a SYNC_STAGES-flop synchronizer; all decisions SHALL use the synchronized copies only.
REQ-005 Address map:
- 0..MEMORY_BYTES-1: memory (write -> memory_input, read <- memory_output).
- MEMORY_BYTES: CTRL on write, STATUS on read.
- All other addresses: writes ignored, reads return 0x00.
REQ-006 The FSM SHALL have the states IDLE, WR_ACTIVE, RD_FETCH, RD_HOLD and RD_TAIL.
REQ-007 In IDLE with synchronized cen low:
- wr low and rd high -> WR_ACTIVE.
- rd low and wr high -> RD_FETCH.
- Both low -> stay IDLE and set the sticky err bit.
REQ-008 In WR_ACTIVE the block SHALL register the synchronized addr/data every cycle.
REQ-009 On synchronized wr_en high the block SHALL return to IDLE and, in that same transition cycle, commit the last registered addr/data.
REQ-010 A memory-range commit SHALL update one byte of memory_input and assert wr_pulse for exactly one cycle, with wr_index equal to the address masked to MEMORY_WIDTH bits.
REQ-011 A CTRL write SHALL act on its bits as follows:
- bit0=1 -> go high for exactly one cycle.
- bit1=1 -> clear done_sticky.
- bit2=1 -> clear err.
- All other bits ignored.
- No wr_pulse.
REQ-012 RD_FETCH SHALL last one cycle, latch the read byte into data_out, then go to RD_HOLD.
REQ-013 STATUS SHALL read as {5'b0, err, done_sticky, busy}.
REQ-014 The data bus SHALL be driven with data_out only in RD_HOLD and RD_TAIL, and SHALL be high-Z otherwise.
REQ-015 Drive SHALL begin SYNC_STAGES+2 cycles after the rd_en pin falls; the host SHALL hold rd_en low at least SYNC_STAGES+3 cycles.
REQ-016 RD_HOLD SHALL move to RD_TAIL on synchronized rd_en high.
REQ-017 RD_TAIL SHALL hold drive for exactly RDDLY_LEN cycles using a down-counter, then go to IDLE.
REQ-018 A strobe fall seen in RD_TAIL SHALL be ignored until IDLE is reached.
REQ-019 A synchronized cen high during WR_ACTIVE SHALL abort the write: go to IDLE with no commit and no wr_pulse.
REQ-020 done_sticky SHALL be set by done=1; if a set and a CTRL clear occur in the same cycle, the set SHALL win.
REQ-021 wr_index SHALL hold its value between commits.

Reset
REQ-022 While reset=1 the block SHALL hold:
- FSM in IDLE.
- memory_input = 0, data_out = 0x00.
- go = 0, wr_pulse = 0, wr_index = 0.
- done_sticky = 0, err = 0.
- Synchronizers at idle (strobes and cen high).
- data at high-Z.
REQ-023 A reset asserted mid-transfer SHALL abandon that transfer with no commit; the next transfer SHALL be recognised only after its strobe is seen high and then low again.

Structure
REQ-024 The FSM state encoding and the CTRL/STATUS bit positions SHALL live in the shared package usb_reg_pkg.
REQ-025 The synchronizer SHALL be the sub-module usb_sync (parameter WIDTH, STAGES), instantiated once per synchronized signal group.
REQ-026 Clock buffering SHALL stay outside this block.

Verification
REQ-027 Write 0xA5 to addr 0x003 -> memory_input[31:24]=0xA5, a single wr_pulse with wr_index=3, all other bytes unchanged.
REQ-028 memory_output byte 0x10 = 0x3C, read addr 0x010 -> data=0x3C driven from cycle SYNC_STAGES+2 after the rd fall, high-Z exactly RDDLY_LEN cycles after the synchronized rd rise.
REQ-029 Write 0x01 to addr 0x100 -> go high for exactly one cycle; pulse done, then read 0x100 -> 0x02; write 0x02 -> next read returns 0x00.
REQ-030 Read addr 0x1FFFFF -> data 0x00; write to 0x000200 -> memory_input unchanged, no wr_pulse.
REQ-031 Drive rd_en and wr_en low together -> no commit, no drive; next STATUS read returns 0x04.
REQ-032 Assert reset during RD_HOLD -> data high-Z the next cycle; memory_input all zero after reset.
